// File: rtl/fp_normalizer.sv
// fp_normalizer
//   Post-add normaliser for IEEE-754 single precision. It takes the raw
//   mantissa sum from the adder. In a SHIFT state it applies one
//   normalisation step per cycle, either a carry right-shift or a left
//   shift, until the value is normal, zero, infinite or denormal. The
//   packed result is then held in DONE until downstream accepts it.
//
//   Build option: FPN_UNDERFLOW_FLUSH_EN
//     defined   -> a denormal stop packs signed zero {sign, 31'h0}
//     undefined -> a denormal stop packs {sign, 8'h00, sum[22:0]}
//
//   Ports
//     clk        sole clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   adder result present
//     in_ready   high only in IDLE
//     in_sign    result sign
//     in_exp     larger-operand biased exponent
//     in_sum     raw sum (bit 24 carry, bit 23 hidden)
//     in_inf     adder flagged an infinite operand
//     out_valid  packed result available (state only, no out_ready path)
//     out_ready  downstream accepts result
//     out        {sign, exp, mantissa}
//     shift_cnt  left shifts applied to the current/last result
//
//   state | meaning
//   IDLE  | waiting for an adder result, in_ready high
//   SHIFT | one normalisation step per cycle
//   DONE  | out_valid high, out held until out_ready
module fp_normalizer #(
  parameter int EXP_W = 8,
  parameter int SUM_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out,
  output logic [4:0]       shift_cnt
);

  localparam int MAN_W = SUM_W - 2;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   EXP_INF = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_sign;
  logic [EXP_W-1:0] r_exp;
  logic [SUM_W-1:0] r_sum;
  logic             r_inf;
  logic [4:0]       r_cnt;
  logic [31:0]      r_out;

  logic             w_stop;
  logic             w_shift_l;
  logic [31:0]      w_pack;
  logic [EXP_W:0]   w_exp_inc;

  // One extra bit so a carry out of exponent 255 cannot wrap silently.
  assign w_exp_inc = {1'b0, r_exp} + {{EXP_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stop      = 1'b0;
    w_shift_l   = 1'b0;
    w_pack      = '0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_inf) begin
          w_stop = 1'b1;
          w_pack = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (r_sum == '0) begin
          // Exact cancellation always gives positive zero.
          w_stop = 1'b1;
          w_pack = '0;
        end else if (r_sum[SUM_W-1]) begin
          w_stop = 1'b1;
          if (w_exp_inc >= EXP_INF) begin
            w_pack = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else begin
            // Right shift by one: mantissa becomes sum[23:1].
            w_pack = {r_sign, w_exp_inc[EXP_W-1:0], r_sum[SUM_W-2:1]};
          end
        end else if (r_sum[SUM_W-2]) begin
          w_stop = 1'b1;
          w_pack = {r_sign, r_exp, r_sum[MAN_W-1:0]};
        end else if (r_exp <= EXP_ONE) begin
          // Exponent 0 is treated like 1 so a zero-exponent input cannot wrap.
          w_stop = 1'b1;
`ifdef FPN_UNDERFLOW_FLUSH_EN
          w_pack = {r_sign, 31'h0};
`else
          w_pack = {r_sign, {EXP_W{1'b0}}, r_sum[MAN_W-1:0]};
`endif
        end else begin
          w_shift_l = 1'b1;
        end
        if (w_stop) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_sum  <= '0;
      r_inf  <= 1'b0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_sign <= in_sign;
        r_exp  <= in_exp;
        r_sum  <= in_sum;
        r_inf  <= in_inf;
        r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        if (w_stop) begin
          r_out <= w_pack;
        end else if (w_shift_l) begin
          r_sum <= {r_sum[SUM_W-2:0], 1'b0};
          r_exp <= r_exp - EXP_ONE;
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign shift_cnt = r_cnt;

endmodule

// File: tb/tb_fp_normalizer.sv
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_sum;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  shift_cnt;

  int checks   = 0;
  int failures = 0;

  fp_normalizer #(.EXP_W(8), .SUM_W(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sum    (in_sum),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .shift_cnt (shift_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge. The cycle in
  // which in_valid is presented is cycle 0, so a result needing no left
  // shift is first valid in cycle 2.
  task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                         input logic [24:0] m, input logic inf,
                         input logic [31:0] exp_out, input int exp_cnt,
                         input int exp_lat, input int hold);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_sum    = m;
    in_inf    = inf;
    out_ready = (hold == 0);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_cnt"}, {27'h0, shift_cnt}, exp_cnt);
    held = out;
    for (int i = 0; i < hold; i++) begin
      // A new request while busy must be ignored.
      in_valid = 1'b1;
      in_sign  = ~s;
      in_sum   = 25'h0800000;
      in_inf   = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
      check({tag, "_hold_out"}, out, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_released"}, {30'h0, out_valid, in_ready}, 32'h1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h0;
    in_sum    = 25'h0;
    in_inf    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out", out, 32'h0);
    check("rst_cnt", {27'h0, shift_cnt}, 32'h0);
    rst = 1'b0;

    run_vec("norm",    1'b0, 8'd130, 25'h0A50000, 1'b0, 32'h41250000, 0, 2, 0);
    run_vec("carry",   1'b0, 8'd136, 25'h1900000, 1'b0, 32'h44C80000, 0, 2, 0);
    run_vec("shift23", 1'b0, 8'd130, 25'h0000001, 1'b0, 32'h35800000, 23, 25, 0);
    run_vec("shift1",  1'b0, 8'd128, 25'h0600000, 1'b0, 32'h3FC00000, 1, 3, 0);
    run_vec("zero",    1'b1, 8'd100, 25'h0000000, 1'b0, 32'h00000000, 0, 2, 0);
    run_vec("inf",     1'b1, 8'd50,  25'h0123456, 1'b1, 32'hFF800000, 0, 2, 0);
`ifdef FPN_UNDERFLOW_FLUSH_EN
    run_vec("denorm",  1'b0, 8'd3,   25'h0000400, 1'b0, 32'h00000000, 2, 4, 0);
`else
    run_vec("denorm",  1'b0, 8'd3,   25'h0000400, 1'b0, 32'h00001000, 2, 4, 0);
`endif
    run_vec("ovf",     1'b0, 8'd254, 25'h1000000, 1'b0, 32'h7F800000, 0, 2, 0);
    run_vec("hold",    1'b1, 8'd127, 25'h0C00000, 1'b0, 32'hBFC00000, 0, 2, 5);

    // Reset in the middle of a long left-shift run, with in_valid also high.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'd130;
    in_sum   = 25'h0000001;
    in_inf   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_cnt", {27'h0, shift_cnt}, 32'd4);
    check("mid_busy", {31'h0, in_ready}, 32'h0);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("mid_rst_out", out, 32'h0);
    check("mid_rst_cnt", {27'h0, shift_cnt}, 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {30'h0, out_valid, in_ready}, 32'h1);

    run_vec("after_rst", 1'b0, 8'd130, 25'h0A50000, 1'b0, 32'h41250000, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (only 8 supported).
REQ-002 SHALL have parameter SUM_W, default 25, raw sum width (bit 24 carry, bit 23 hidden).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port in_valid  input  1  upstream adder result present.
REQ-006 SHALL have port in_ready  output  1  block can accept a result.
REQ-007 SHALL have port in_sign  input  1  result sign from the adder.
REQ-008 SHALL have port in_exp  input  8  larger-operand biased exponent.
REQ-009 SHALL have port in_sum  input  25  raw unnormalised mantissa sum.
REQ-010 SHALL have port in_inf  input  1  adder flagged infinity operand.
REQ-011 SHALL have port out_valid  output  1  packed result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out  output  32  IEEE-754 single result {sign, exp, mantissa}.
REQ-014 SHALL have port shift_cnt  output  5  left shifts applied to the current/last result.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL, in IDLE with in_valid=1, latch sign, exp, sum, inf, clear shift_cnt, go to SHIFT.
REQ-017 SHALL, in SHIFT each cycle, apply the first matching rule: inf -> DONE; sum==0 -> DONE; sum[24]=1 -> sum>>1, exp+1, DONE; sum[23]=1 -> DONE; exp==1 -> DONE (denormal); else sum<<1, exp-1, shift_cnt+1, stay.
REQ-018 SHALL, in DONE, assert out_valid and hold out stable until out_ready=1, then return to IDLE the next cycle.
REQ-019 SHALL give latency: out_valid first high 2 cycles after the accept edge plus one cycle per left shift (max 22 left shifts before exp reaches 1, or 23 from exp 24+).
REQ-020 SHALL pack normal result as {sign, exp, sum[22:0]}.
REQ-021 SHALL pack inf as {sign, 8'hFF, 23'h0} regardless of sum.
REQ-022 SHALL pack sum==0 as 32'h00000000 (positive zero).
REQ-023 SHALL pack carry with exp reaching 255 as {sign, 8'hFF, 23'h0}.
REQ-024 SHALL pack denormal stop (exp==1, sum[23]=0) as {sign, 8'h00, sum[22:0]}.
REQ-025 SHALL ignore in_valid outside IDLE (no queueing); only one result in flight.
REQ-026 SHALL not combinationally depend out_valid on out_ready.

Reset
REQ-027 SHALL on rst=1 go to IDLE, out_valid=0, out=0, shift_cnt=0, in_ready=1 next cycle.
REQ-028 SHALL abandon any in-progress or undelivered result when rst asserts in SHIFT or DONE.
REQ-029 SHALL give rst priority over in_valid and out_ready in the same cycle.

Configuration
REQ-030 SHALL honour macro FPN_UNDERFLOW_FLUSH_EN: defined -> denormal stop packs {sign, 31'h0}; undefined -> denormal per REQ-024.

Verification
REQ-031 SHALL test: sign 0, exp 130, sum 25'h0A50000 -> out 32'h41250000, shift_cnt 0, out_valid 2 cycles after accept.
REQ-032 SHALL test: sign 0, exp 136, sum 25'h1900000 -> out 32'h44C80000 (1600.0) at accept+2.
REQ-033 SHALL test: exp 130, sum 25'h0000001 -> out 32'h35800000, shift_cnt 23, out_valid at accept+25.
REQ-034 SHALL test: sum 0 -> 32'h00000000; in_inf=1, sign 1 -> 32'hFF800000.
REQ-035 SHALL test: exp 3, sum 25'h0000400 -> 32'h00001000 (flush build: 32'h00000000), shift_cnt 2.
REQ-036 SHALL test: out_ready=0 for 5 cycles holds out stable; rst pulse mid-SHIFT -> out_valid 0, in_ready 1 next cycle.
